// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync and
// blanking outputs aligned to the counters, plus end-of-line/frame strobes.
module vga_sync_gen #(
    parameter int H_DISPLAY  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_DISPLAY  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_end,
    output logic       frame_end
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    generate
        if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_timing
            $error("vga_sync_gen: H_TOTAL and V_TOTAL must fit in 10-bit counters");
        end
    endgenerate

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    // Window bounds are 11 bits so an end bound of 1024 still compares correctly.
    localparam logic [10:0] H_VIS      = 11'(H_DISPLAY);
    localparam logic [10:0] V_VIS      = 11'(V_DISPLAY);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] H_SYNC_FIN = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] V_SYNC_FIN = 11'(V_DISPLAY + V_FRONT + V_SYNC);

    function automatic logic in_hsync(input logic [9:0] h);
        return ({1'b0, h} >= H_SYNC_BEG) && ({1'b0, h} < H_SYNC_FIN);
    endfunction

    function automatic logic in_vsync(input logic [9:0] v);
        return ({1'b0, v} >= V_SYNC_BEG) && ({1'b0, v} < V_SYNC_FIN);
    endfunction

    function automatic logic visible(input logic [9:0] h, input logic [9:0] v);
        return ({1'b0, h} < H_VIS) && ({1'b0, v} < V_VIS);
    endfunction

    function automatic logic pin_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

    logic [9:0] r_hpos;
    logic [9:0] r_vpos;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_display_on;

    logic       w_h_wrap;
    logic       w_v_wrap;
    logic [9:0] w_hpos_nxt;
    logic [9:0] w_vpos_nxt;

    always_comb begin
        w_h_wrap   = (r_hpos == H_LAST);
        w_v_wrap   = (r_vpos == V_LAST);
        w_hpos_nxt = w_h_wrap ? 10'd0 : r_hpos + 10'd1;
        w_vpos_nxt = r_vpos;
        if (w_h_wrap) begin
            w_vpos_nxt = w_v_wrap ? 10'd0 : r_vpos + 10'd1;
        end
    end

    // Pin outputs are decoded from the next counter values so they land on the
    // same edge as the counters they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hpos       <= 10'd0;
            r_vpos       <= 10'd0;
            r_hsync      <= ~H_SYNC_POL;
            r_vsync      <= ~V_SYNC_POL;
            r_display_on <= 1'b1;
        end else if (pix_en) begin
            r_hpos       <= w_hpos_nxt;
            r_vpos       <= w_vpos_nxt;
            r_hsync      <= pin_level(in_hsync(w_hpos_nxt), H_SYNC_POL);
            r_vsync      <= pin_level(in_vsync(w_vpos_nxt), V_SYNC_POL);
            r_display_on <= visible(w_hpos_nxt, w_vpos_nxt);
        end
    end

    assign hpos       = r_hpos;
    assign vpos       = r_vpos;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign display_on = r_display_on;

    // Strobes are suppressed while reset is held so an interrupted line never
    // reports an end.
    assign line_end   = pix_en && !reset && w_h_wrap;
    assign frame_end  = line_end && w_v_wrap;

endmodule
